// File: rtl/instr_fetch.sv
// Instruction fetch: loads the program through read_file, then reads it word by word and hands each one to decode.
// Optional: define HALT_OPCODE_EN so that an accepted word with opcode 4'hF ends the fetch.
module instr_fetch #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              read_file,
  input  logic              fin_file,
  output logic              read_memory,
  output logic [ADDR_W-1:0] pos,
  input  logic [DATA_W-1:0] return_instr_line,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_WAIT, S_CAPT, S_HOLD, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST_LEN = (ADDR_W+1)'(MEM_DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] pc;
`ifdef HALT_OPCODE_EN
  logic            halt_q;
`endif

  assign state_dbg = state;

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
  // instr_out/pc_out are held unchanged while instr_valid is high and not yet accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      prog_len    <= '0;
      read_file   <= 1'b0;
      read_memory <= 1'b0;
      pos         <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_err    <= 1'b0;
`ifdef HALT_OPCODE_EN
      halt_q      <= 1'b0;
`endif
    end else if (branch_valid && (state inside {S_REQ, S_WAIT, S_CAPT, S_HOLD})) begin
      // A redirect drops whatever read is in flight and wins over a same-cycle accept.
      pc          <= {1'b0, branch_target};
      instr_valid <= 1'b0;
      read_memory <= 1'b0;
      state       <= S_REQ;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            read_file <= 1'b1;
            prog_len  <= '0;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (fin_file) begin
            read_file <= 1'b0;
            pc        <= '0;
            state     <= S_REQ;
          end else begin
            prog_len <= prog_len + 1'b1;
            if (prog_len == LAST_LEN) begin
              read_file <= 1'b0;
              load_err  <= 1'b1;
              pc        <= '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (pc >= prog_len) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pos         <= pc[ADDR_W-1:0];
            read_memory <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          read_memory <= 1'b0;
          state       <= S_CAPT;
        end
        S_CAPT: begin
          instr_out   <= return_instr_line;
          pc_out      <= pc[ADDR_W-1:0];
          instr_valid <= 1'b1;
`ifdef HALT_OPCODE_EN
          halt_q      <= (return_instr_line[DATA_W-1 -: 4] == 4'hF);
`endif
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + 1'b1;
`ifdef HALT_OPCODE_EN
            if (halt_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_REQ;
            end
`else
            state <= S_REQ;
`endif
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of load/fetch scenarios against a transaction-level model, plus directed corner cases.
module tb_instr_fetch;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 400;

  logic              clk;
  logic              rst;
  logic              start;
  logic              read_file;
  logic              fin_file;
  logic              read_memory;
  logic [ADDR_W-1:0] pos;
  logic [DATA_W-1:0] return_instr_line;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              done;
  logic              load_err;
  logic [2:0]        state_dbg;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .read_file(read_file), .fin_file(fin_file),
    .read_memory(read_memory), .pos(pos), .return_instr_line(return_instr_line),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_valid(branch_valid), .branch_target(branch_target),
    .prog_len(prog_len), .busy(busy), .done(done), .load_err(load_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: file length counter and a read port with one register stage
  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] rdata = '0;
  int file_len = 0;
  int load_cnt = 0;
  int rm_cnt   = 0;
  int n_vec    = 0;
  int n_err    = 0;

  always @(posedge clk) if (read_memory) rdata <= mem[pos];
  assign return_instr_line = rdata;
  always @(posedge clk) begin
    if (start) load_cnt <= 0;
    else if (read_file && !fin_file) load_cnt <= load_cnt + 1;
  end
  assign fin_file = read_file && (load_cnt == file_len);
  always @(posedge clk) if (read_memory) rm_cnt <= rm_cnt + 1;

  typedef struct {
    int file_len;
    int exp_plen;
    bit exp_err;
    int rdy_pct;
    int br_pct;
  } row_t;
  row_t rows[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; instr_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 512; i++) mem[i] = 16'h1001 + 16'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom) & 16'hEFFF;
  endtask

  // Ends on the negedge where read_file has dropped (fetch begins at pc 0).
  task automatic load_prog(input int flen);
    file_len = flen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!read_file) return;
      @(negedge clk);
    end
    timeout_fail("load_end");
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60; i++) begin
      if (instr_valid) return;
      @(negedge clk);
    end
    timeout_fail(name);
  endtask

  // Scoreboard: the expected pc follows the program order, redirected by every branch.
  task automatic run_fetch(input int plen, input int rdy_pct, input int br_pct);
    int exp_pc = 0;
    int n_acc = 0;
    int n_br = 0;
    int first_v = -1;
    int tgt = 0;
    int lo, hi;
    bit rdy, br, fin;
    bit prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_instr = '0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 40 * plen + 100; cyc++) begin
      if (done) begin fin = 1'b1; break; end
      if (prev_hold) begin
        check("hold_valid", instr_valid, 1);
        check("hold_stable", instr_out, prev_instr);
      end
      if (instr_valid && first_v < 0) first_v = cyc;
      rdy = ($urandom_range(99) < rdy_pct);
      br  = (exp_pc < plen) && (n_br < 8) && ($urandom_range(99) < br_pct);
      if (br) begin
        lo = (exp_pc > 4) ? exp_pc - 4 : 0;
        hi = (exp_pc + 6 > plen) ? plen : exp_pc + 6;
        tgt = $urandom_range(hi, lo);
        n_br++;
      end
      if (instr_valid && rdy && !br) begin
        check("fetch_pc", pc_out, exp_pc);
        check("fetch_instr", instr_out, mem[exp_pc]);
        exp_pc++;
        n_acc++;
      end
      if (br) exp_pc = tgt;
      prev_hold  = instr_valid && !rdy && !br;
      prev_instr = instr_out;
      instr_ready   = rdy;
      branch_valid  = br;
      branch_target = tgt[ADDR_W-1:0];
      @(negedge clk);
    end
    instr_ready = 1'b0;
    branch_valid = 1'b0;
    if (!fin) timeout_fail("fetch_done");
    check("end_pc_reached", (exp_pc >= plen), 1);
    check("done", done, 1);
    check("busy_done", busy, 0);
    if (br_pct == 0) check("accept_count", n_acc, plen);
    if (br_pct == 0 && plen > 0) check("first_latency", first_v, 3);
  endtask

  initial begin
    int rm0;
    int n_acc;
    int last_pc;
    logic [DATA_W-1:0] last_instr;

    rows[0] = '{file_len: 5,    exp_plen: 5,   exp_err: 1'b0, rdy_pct: 100, br_pct: 0};
    rows[1] = '{file_len: 0,    exp_plen: 0,   exp_err: 1'b0, rdy_pct: 100, br_pct: 0};
    rows[2] = '{file_len: 1,    exp_plen: 1,   exp_err: 1'b0, rdy_pct: 50,  br_pct: 0};
    rows[3] = '{file_len: 1000, exp_plen: 400, exp_err: 1'b1, rdy_pct: 100, br_pct: 0};
    rows[4] = '{file_len: 399,  exp_plen: 399, exp_err: 1'b0, rdy_pct: 100, br_pct: 0};
    rows[5] = '{file_len: 40,   exp_plen: 40,  exp_err: 1'b0, rdy_pct: 60,  br_pct: 15};
    rows[6] = '{file_len: 64,   exp_plen: 64,  exp_err: 1'b0, rdy_pct: 30,  br_pct: 25};

    // reset state, and branch/no-start in IDLE stays idle
    do_reset();
    check("rst_read_file", read_file, 0);
    check("rst_read_memory", read_memory, 0);
    check("rst_pos", pos, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_err", load_err, 0);
    branch_valid = 1'b1; branch_target = 9'd3;
    @(negedge clk);
    branch_valid = 1'b0;
    @(negedge clk);
    check("idle_branch_busy", busy, 0);

    // table of load/fetch scenarios
    for (int r = 0; r < 7; r++) begin
      do_reset();
      if (r == 0) fill_seq(); else fill_rand();
      rm0 = rm_cnt;
      load_prog(rows[r].file_len);
      check("prog_len", prog_len, rows[r].exp_plen);
      check("load_err", load_err, rows[r].exp_err);
      check("read_file_off", read_file, 0);
      check("busy_fetch", busy, 1);
      run_fetch(rows[r].exp_plen, rows[r].rdy_pct, rows[r].br_pct);
      if (rows[r].br_pct == 0) check("read_pulses", rm_cnt - rm0, rows[r].exp_plen);
    end

    // backpressure at pc 2
    do_reset(); fill_seq(); load_prog(5);
    instr_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (instr_valid && pc_out == 9'd2) break;
      @(negedge clk);
    end
    instr_ready = 1'b0;
    rm0 = rm_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", instr_valid, 1);
      check("bp_instr", instr_out, 16'h1003);
      check("bp_pos", pos, 2);
    end
    check("bp_no_read", rm_cnt - rm0, 0);
    instr_ready = 1'b1;
    @(negedge clk);
    wait_valid("bp_next");
    check("bp_next_pc", pc_out, 3);
    check("bp_next_instr", instr_out, 16'h1004);

    // branch while the read of pc 1 is in flight
    do_reset(); fill_seq(); load_prog(5);
    instr_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (read_memory && pos == 9'd1) break;
      @(negedge clk);
    end
    branch_valid = 1'b1; branch_target = 9'd4;
    @(negedge clk);
    branch_valid = 1'b0;
    wait_valid("br_wait_next");
    check("br_wait_pc", pc_out, 4);
    check("br_wait_instr", instr_out, 16'h1005);

    // branch and accept in the same cycle
    do_reset(); fill_seq(); load_prog(5);
    instr_ready = 1'b0;
    wait_valid("br_acc_first");
    check("br_acc_first_pc", pc_out, 0);
    instr_ready = 1'b1; branch_valid = 1'b1; branch_target = 9'd3;
    @(negedge clk);
    branch_valid = 1'b0;
    wait_valid("br_acc_next");
    check("br_acc_pc", pc_out, 3);
    check("br_acc_instr", instr_out, 16'h1004);

    // opcode F word at pc 1
    do_reset(); fill_seq(); mem[1] = 16'hF000; load_prog(5);
    instr_ready = 1'b1;
    n_acc = 0; last_pc = -1; last_instr = '0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (instr_valid) begin n_acc++; last_pc = int'(pc_out); last_instr = instr_out; end
      @(negedge clk);
    end
    check("halt_done", done, 1);
`ifdef HALT_OPCODE_EN
    check("halt_count", n_acc, 2);
    check("halt_last_pc", last_pc, 1);
    check("halt_last_instr", last_instr, 16'hF000);
`else
    check("f_op_count", n_acc, 5);
    check("f_op_last_pc", last_pc, 4);
    check("f_op_last_instr", last_instr, 16'h1005);
`endif

    // asynchronous reset while a word is held
    do_reset(); fill_seq(); load_prog(5);
    instr_ready = 1'b0;
    wait_valid("rst_hold");
    #2 rst = 1'b0;
    #1;
    check("arst_instr_valid", instr_valid, 0);
    check("arst_instr_out", instr_out, 0);
    check("arst_pc_out", pc_out, 0);
    check("arst_pos", pos, 0);
    check("arst_prog_len", prog_len, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("arst_idle_busy", busy, 0);
    load_prog(3);
    check("arst_reload_len", prog_len, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Initiator/consumer side of the instruction memory interface.
- Drives the memory's file-load strobe (read_file) until end-of-file is reported, counting the loaded program length.
- Then sequences instruction reads by program counter (read_memory/pos) and presents each fetched 16-bit word to the decoder through a valid/ready handshake.
- Accepts branch redirects from downstream; sits between instruction memory and decode.

Parameters:
ADDR_W, 9, width of pos / program counter
DATA_W, 16, instruction word width
MEM_DEPTH, 400, number of valid memory locations; load and fetch never address beyond MEM_DEPTH-1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins load sequence from IDLE
read_file  output  1  load strobe to memory (registered)
fin_file  input  1  end-of-file flag from memory
read_memory  output  1  read strobe to memory (registered)
pos  output  ADDR_W  read address to memory (registered)
return_instr_line  input  DATA_W  read data from memory, valid on the 2nd rising edge after pos/read_memory update
instr_out  output  DATA_W  fetched instruction
pc_out  output  ADDR_W  address of instr_out
instr_valid  output  1  instr_out/pc_out valid
instr_ready  input  1  decoder accepts when instr_valid & instr_ready
branch_valid  input  1  redirect request
branch_target  input  ADDR_W  redirect address
prog_len  output  ADDR_W+1  number of words loaded
busy  output  1  high outside IDLE and DONE
done  output  1  high in DONE
load_err  output  1  sticky; program hit MEM_DEPTH before fin_file

Behaviour:
- Reset (rst=0, async): state IDLE, pc=0, prog_len=0.
- Reset values: read_file=0, read_memory=0, pos=0, instr_out=0, pc_out=0, instr_valid=0, busy=0, done=0, load_err=0.
- Reset mid-operation aborts immediately to these values.
- States: IDLE, LOAD, REQ, WAIT, CAPT, HOLD, DONE.
- IDLE: on start go to LOAD, read_file<=1, prog_len<=0. start is ignored in all other states.
- LOAD, read_file=1: at each edge with read_file=1 and fin_file=0, prog_len<=prog_len+1.
  - fin_file=1 sampled: read_file<=0, pc<=0, go to REQ.
  - prog_len reaches MEM_DEPTH before fin_file: read_file<=0, load_err<=1, go to REQ (program truncated to MEM_DEPTH).
- REQ:
  - prog_len==0: go to DONE.
  - pc>=prog_len: go to DONE.
  - Otherwise pos<=pc, read_memory<=1, go to WAIT.
- WAIT: read_memory<=0; go to CAPT (memory registers data this edge).
- CAPT: instr_out<=return_instr_line, pc_out<=pc, instr_valid<=1, go to HOLD.
- HOLD: instr_valid held, instr_out stable until accepted.
  - On accept: instr_valid<=0, pc<=pc+1, go to REQ.
- Fetch latency: 3 cycles from REQ entry to instr_valid; one instruction per 4 cycles at instr_ready=1.
- Branch: branch_valid in REQ/WAIT/CAPT/HOLD:
  - pc<=branch_target, instr_valid<=0, read_memory<=0, go to REQ.
  - Any in-flight read is discarded.
  - Branch and accept in the same cycle: branch wins, pc=branch_target (no +1).
  - branch_valid in IDLE/LOAD/DONE is ignored.
  - branch_target>=prog_len leads to DONE via the REQ check.
- pc increment is ADDR_W+1 wide; no wrap. pc==prog_len terminates fetch.
- DONE: done=1, all strobes 0. Leaves only by reset.

Optional Feature:
- Macro: HALT_OPCODE_EN.
- Defined: in CAPT, if return_instr_line[15:12]==4'hF, the word is still presented with instr_valid. On its accept, go to DONE instead of REQ.
- Undefined: opcode 4'hF is an ordinary instruction; only pc>=prog_len ends fetch.

Test Plan:
- Load 5 words: fin_file rises on 5th read edge -> prog_len=5, read_file falls next edge, load_err=0.
- Sequential fetch, instr_ready=1, memory words 0x1001..0x1005 -> instr_out/pc_out pairs (0x1001,0)...(0x1005,4), instr_valid 3 cycles after REQ, done=1 after pc=5.
- Backpressure: instr_ready=0 for 6 cycles at pc=2 -> instr_out=0x1003 stable, pos unchanged, no new read_memory pulse.
- Branch during WAIT at pc=1, target=4 -> pc=1 word never valid, next valid instr_out=0x1005, pc_out=4; simultaneous branch+accept at pc=0 target=3 -> next pc_out=3.
- Overflow/empty:
  - fin_file never rises -> load stops at prog_len=400, load_err=1.
  - fin_file high on first sample -> prog_len=0, DONE, no read_memory pulse.
- Reset low during HOLD -> all outputs zero asynchronously, state IDLE; with HALT_OPCODE_EN, word 0xF000 at pc=1 -> accepted then done=1, pc 2 never fetched.
